// File: rtl/clb_cfg_pkg.sv
// Shared constants, field layout and FSM state type for the CLB configuration loader.
package clb_cfg_pkg;

  localparam int unsigned CFG_W = 37;

  localparam int unsigned MEM_LSB        = 21;
  localparam int unsigned MEM_W          = 16;
  localparam int unsigned COMBOPTION_LSB = 19;
  localparam int unsigned COMBOPTION_W   = 2;
  localparam int unsigned MUX2_LSB       = 17;
  localparam int unsigned MUX3_LSB       = 15;
  localparam int unsigned MUX4_LSB       = 13;
  localparam int unsigned MUX5_LSB       = 11;
  localparam int unsigned MUX6_LSB       = 9;
  localparam int unsigned MUX_W          = 2;
  localparam int unsigned O2M1_0_LSB     = 8;
  localparam int unsigned O2M2_0_LSB     = 7;
  localparam int unsigned O2M3_0_LSB     = 6;
  localparam int unsigned O2M1_1_LSB     = 5;
  localparam int unsigned O2M2_1_LSB     = 4;
  localparam int unsigned O2M3_1_LSB     = 3;
  localparam int unsigned DQMUX1_LSB     = 2;
  localparam int unsigned DQMUX2_LSB     = 1;
  localparam int unsigned FLOPORLATCH_LSB = 0;

  // mem 16'h0116, S/R/K muxes 2'b10, X/Y muxes 2'b00, o2m 6'b000111, latch off
  localparam logic [CFG_W-1:0] CFG_DEFAULT = 37'h0022C54038;

  localparam logic [7:0] PREAMBLE_DEFAULT = 8'hB2;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    FRAME,
    PARITY,
    COMMIT,
    DONE,
    ERROR
  } clb_cfg_state_e;

endpackage

// File: rtl/clb_cfg_loader_if.sv
// Serial bitstream handshake and status between the boot interface and the loader.
interface clb_cfg_loader_if;
  logic cfg_start;
  logic cfg_din;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_busy;
  logic cfg_done;
  logic cfg_err;

  modport master (
    output cfg_start, cfg_din, cfg_valid,
    input  cfg_ready, cfg_busy, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_start, cfg_din, cfg_valid,
    output cfg_ready, cfg_busy, cfg_done, cfg_err
  );
endinterface

// File: rtl/clb_cfg_frame_shifter.sv
// One-frame shift register, MSB first, with running XOR parity and bit counter.
module clb_cfg_frame_shifter
  import clb_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [CFG_W-1:0] ld_word,
  input  logic             shift,
  input  logic             din,
  output logic [CFG_W-1:0] word,
  output logic             parity,
  output logic             last
);

  localparam int unsigned CNT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

  logic [CFG_W-1:0] word_q, word_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    par_d  = par_q;
    cnt_d  = cnt_q;
    if (clr) begin
      word_d = '0;
      par_d  = 1'b0;
      cnt_d  = '0;
    end else if (ld) begin
      word_d = ld_word;
      par_d  = 1'b0;
      cnt_d  = '0;
    end else if (shift) begin
      word_d = {word_q[CFG_W-2:0], din};
      par_d  = par_q ^ din;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      par_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      par_q  <= par_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word   = word_q;
  assign parity = par_q;
  // True while the bit being shifted in this cycle is the frame's final data bit.
  assign last   = (cnt_q == CNT_W'(CFG_W - 1));

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: preamble sync, per-frame parity, shadow assembly, atomic commit.
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int unsigned NUM_CLB  = 4,
  parameter logic [7:0]  PREAMBLE = PREAMBLE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  clb_cfg_loader_if.slave          cfg,
  output logic [NUM_CLB*CFG_W-1:0] cfg_active
);

  localparam int unsigned IDX_W = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;

  clb_cfg_state_e             state_q, state_d;
  logic [7:0]                 win_q, win_d, win_nxt;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_CLB*CFG_W-1:0]   shadow_q, shadow_d;
  logic [NUM_CLB*CFG_W-1:0]   active_q, active_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic                       accept;
  logic                       sh_clr, sh_ld, sh_shift;
  logic [CFG_W-1:0]           sh_word;
  logic                       sh_par, sh_last;

  clb_cfg_frame_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .clr     (sh_clr),
    .ld      (sh_ld),
    .ld_word (CFG_DEFAULT),
    .shift   (sh_shift),
    .din     (cfg.cfg_din),
    .word    (sh_word),
    .parity  (sh_par),
    .last    (sh_last)
  );

  assign accept  = cfg.cfg_valid && ready_q;
  assign win_nxt = {win_q[6:0], cfg.cfg_din};

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    sh_clr   = 1'b0;
    sh_ld    = 1'b0;
    sh_shift = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (cfg.cfg_start) begin
          state_d  = SYNC;
          err_d    = 1'b0;
          shadow_d = {NUM_CLB{CFG_DEFAULT}};
          idx_d    = '0;
          win_d    = '0;
          sh_ld    = 1'b1;
        end
      end
      SYNC: begin
        if (accept) begin
          win_d = win_nxt;
          if (win_nxt == PREAMBLE) begin
            state_d = FRAME;
            sh_clr  = 1'b1;
          end
        end
      end
      FRAME: begin
        if (accept) begin
          sh_shift = 1'b1;
          if (sh_last) state_d = PARITY;
        end
      end
      PARITY: begin
        if (accept) begin
          if (sh_par ^ cfg.cfg_din) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            for (int unsigned i = 0; i < NUM_CLB; i++) begin
              if (idx_q == IDX_W'(i)) shadow_d[i*CFG_W +: CFG_W] = sh_word;
            end
            sh_clr = 1'b1;
            if (idx_q == IDX_W'(NUM_CLB - 1)) begin
              state_d = COMMIT;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = FRAME;
            end
          end
        end
      end
      COMMIT: begin
        active_d = shadow_q;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    ready_d = (state_d == SYNC) || (state_d == FRAME) || (state_d == PARITY);
    busy_d  = ready_d || (state_d == COMMIT);
    done_d  = (state_q == COMMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= '0;
      idx_q    <= '0;
      shadow_q <= {NUM_CLB{CFG_DEFAULT}};
      active_q <= {NUM_CLB{CFG_DEFAULT}};
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_busy  = busy_q;
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;
  assign cfg_active    = active_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed/randomized bench for clb_cfg_loader with a bit-queue reference model.
module tb_clb_cfg_loader;
  import clb_cfg_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 37;
  localparam logic [W-1:0] DEF = 37'h0022C54038;
  localparam int LOAD_LAT = 8 + N * (W + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clb_cfg_loader_if bus ();
  logic [N*W-1:0] active;

  clb_cfg_loader #(.NUM_CLB(N), .PREAMBLE(8'hB2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (bus),
    .cfg_active (active)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] words   [N];
  logic [W-1:0] exp_act [N];
  logic [W-1:0] happy   [N];
  bit           stream  [$];
  int           pre_idx;
  int           first_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_active(input string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_slice%0d", tag, i), 64'(active[i*W +: W]), 64'(exp_act[i]));
  endtask

  task automatic check_status(input string tag, input logic b, input logic r, input logic d, input logic e);
    chk({tag, "_busy"},  64'(bus.cfg_busy),  64'(b));
    chk({tag, "_ready"}, 64'(bus.cfg_ready), 64'(r));
    chk({tag, "_done"},  64'(bus.cfg_done),  64'(d));
    chk({tag, "_err"},   64'(bus.cfg_err),   64'(e));
  endtask

  task automatic random_words();
    logic [63:0] r;
    for (int i = 0; i < N; i++) begin
      r = {$urandom(), $urandom()};
      words[i] = r[W-1:0];
    end
  endtask

  // Bitstream: junk, preamble, then frames (data MSB first + even-parity bit); stops after a corrupted frame.
  task automatic build_stream(input int junk, input int flip_frame);
    logic [7:0] pre;
    logic       p;
    pre = 8'hB2;
    stream.delete();
    repeat (junk) stream.push_back(1'($urandom_range(0, 1)));
    pre_idx = junk;
    for (int b = 7; b >= 0; b--) stream.push_back(pre[b]);
    for (int f = 0; f < N; f++) begin
      for (int b = W - 1; b >= 0; b--) stream.push_back(words[f][b]);
      p = ^words[f];
      stream.push_back(f == flip_frame ? ~p : p);
      if (f == flip_frame) break;
    end
  endtask

  task automatic start_load();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    check_status("after_start", 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic feed(input int valid_pct, input int start_at, input int rst_at);
    int  ptr;
    int  budget;
    logic v;
    ptr = 0;
    budget = 5000;
    while (ptr < stream.size()) begin
      if (ptr == rst_at) return;
      chk("ready_busy_during_load", 64'({bus.cfg_ready, bus.cfg_busy}), 64'(2'b11));
      v = ($urandom_range(0, 99) < valid_pct);
      bus.cfg_valid = v;
      bus.cfg_din   = stream[ptr];
      bus.cfg_start = (ptr == start_at);
      if (v && ptr == pre_idx) first_cyc = cyc;
      tick();
      if (v) ptr++;
      bus.cfg_start = 1'b0;
      budget--;
      if (budget == 0) begin
        chk("feed_timeout", 64'(ptr), 64'(stream.size()));
        bus.cfg_valid = 1'b0;
        return;
      end
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic finish_ok(input string tag, input bit check_lat);
    int nd;
    check_status({tag, "_commit"}, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_status({tag, "_done"}, 1'b0, 1'b0, 1'b1, 1'b0);
    if (check_lat) chk({tag, "_latency"}, 64'(cyc - first_cyc), 64'(LOAD_LAT));
    for (int i = 0; i < N; i++) exp_act[i] = words[i];
    check_active(tag);
    nd = 0;
    repeat (5) begin
      tick();
      nd += int'(bus.cfg_done);
    end
    chk({tag, "_single_done"}, 64'(nd), 64'(0));
    check_status({tag, "_hold"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_din   = 1'b0;
    bus.cfg_valid = 1'b0;
    for (int i = 0; i < N; i++) exp_act[i] = DEF;
    happy[0] = 37'h1_0000_0001;
    happy[1] = 37'h0_FFFF_FFFF;
    happy[2] = 37'h0_8000_0000;
    happy[3] = 37'h0;

    // Reset state
    @(negedge clk);
    repeat (2) tick();
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_active("reset");
    rst = 1'b0;
    tick();
    check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Parity error in frame 2: outputs keep defaults
    random_words();
    start_load();
    build_stream(3, 2);
    feed(100, -1, -1);
    check_status("parity_err", 1'b0, 1'b0, 1'b0, 1'b1);
    check_active("parity_err");
    repeat (3) tick();
    chk("err_sticky", 64'(bus.cfg_err), 64'(1));

    // Start from ERROR clears the flag; happy path with latency check
    for (int i = 0; i < N; i++) words[i] = happy[i];
    start_load();
    build_stream(3, -1);
    feed(100, -1, -1);
    finish_ok("happy", 1'b1);

    // Random cfg_valid stalls
    random_words();
    start_load();
    build_stream(int'($urandom_range(0, 6)), -1);
    feed(50, -1, -1);
    finish_ok("stall_rand", 1'b0);
    for (int i = 0; i < N; i++) words[i] = happy[i];
    start_load();
    build_stream(3, -1);
    feed(50, -1, -1);
    finish_ok("stall_happy", 1'b0);

    // cfg_start pulsed mid-frame is ignored
    random_words();
    start_load();
    build_stream(3, -1);
    feed(100, 3 + 8 + 10, -1);
    finish_ok("start_in_frame", 1'b1);

    // rst on bit 20 of frame 1 drops back to defaults
    random_words();
    start_load();
    build_stream(3, -1);
    feed(100, -1, 3 + 8 + (W + 1) + 20);
    rst = 1'b1;
    tick();
    for (int i = 0; i < N; i++) exp_act[i] = DEF;
    check_active("mid_rst");
    check_status("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
    tick();
    check_status("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Recovery load after reset
    random_words();
    start_load();
    build_stream(5, -1);
    feed(100, -1, -1);
    finish_ok("recover", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
